qk_row_softmax: RTL and testbench

- Streaming softmax stage directly downstream of the QK score CIM array.
- Accepts one row of 8-bit QK scores, one element per handshake, and buffers the row in an internal RAM while tracking the row maximum.
- Computes max-subtracted exponentials via a LUT, accumulates their sum, forms a reciprocal with a sequential divider, and streams 8-bit normalized probabilities to the attention-weight (score × V) stage.

---
 rtl/qk_row_softmax.sv | 240 ++++++++++++++++++++++++
 tb/tb_qk_row_softmax.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qk_row_softmax.sv
// qk_row_softmax: streaming row softmax placed after the QK score array.
// A row of scores is buffered in a RAM while its maximum is tracked. Each
// element is then replaced by exp2((x - max) / 16) * 255 from a LUT, and
// the exponentials are summed. A restoring divider forms 2^24 / sum. The row
// is finally streamed out as Q0.8 probabilities, in input order.
// Optional build macro: SCORE_SIGNED_EN makes scores two's complement for
// the max comparison. When it is undefined, scores are unsigned.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds data and valid stable until the transfer.
// Ready may be high before valid, and valid may be high before ready.
// state_dbg exposes the FSM state (0 IDLE, 1 LOAD, 2 EXP, 3 DIV, 4 OUT).
module qk_row_softmax #(
   parameter int MAX_SEQUENCE_LENGTH = 2048,
   parameter int ADDR_WIDTH          = 11,
   parameter int BIT_WIDTH           = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  row_start,
   input  logic [ADDR_WIDTH-1:0] seq_len,
   input  logic [BIT_WIDTH-1:0]  score_in,
   input  logic                  score_valid,
   output logic                  score_ready,
   output logic [BIT_WIDTH-1:0]  prob_out,
   output logic                  prob_valid,
   input  logic                  prob_ready,
   output logic                  busy,
   output logic                  row_done,
   output logic [2:0]            state_dbg
);

   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_EXP  = 3'd2,
      S_DIV  = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   state_t               state;
   logic [CW-1:0]        n_len;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        out_cnt;
   logic [BIT_WIDTH-1:0] max_val;
   logic [18:0]          sum;
   logic [18:0]          rem;
   logic [4:0]           div_cnt;
   logic [16:0]          recip;
   logic                 rd_vld;

   logic [BIT_WIDTH-1:0] ram [MAX_SEQUENCE_LENGTH];
   logic [BIT_WIDTH-1:0] ram_rdata;
   logic                 ram_we;
   logic                 ram_re;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [BIT_WIDTH-1:0] ram_wdata;

   logic                 accept;
   logic                 score_gt;
   logic                 out_fire;
   logic                 load_out;
   logic                 rd_issue;
   logic [BIT_WIDTH-1:0] exp_d;
   logic [BIT_WIDTH-1:0] exp_val;
   logic [19:0]          rem_sh;
   logic                 rem_ge;
   logic [8:0]           scaled;
   logic [BIT_WIDTH-1:0] prob_next;

   // Rounded 255 * 2^(-d/16). The base is 255 * 2^(-r/16) in 8.12 fixed point
   // for r = d[3:0]. It is shifted by q = d[7:4] and rounded half-up. For
   // q > 8 the result is always below one half, so it rounds to 0.
   function automatic logic [7:0] exp_lut(input logic [7:0] d);
      logic [19:0] base;
      logic [4:0]  sh;
      case (d[3:0])
         4'd1:    base = 20'd1000197;
         4'd2:    base = 20'd957792;
         4'd3:    base = 20'd917185;
         4'd4:    base = 20'd878299;
         4'd5:    base = 20'd841062;
         4'd6:    base = 20'd805404;
         4'd7:    base = 20'd771258;
         4'd8:    base = 20'd738559;
         4'd9:    base = 20'd707246;
         4'd10:   base = 20'd677261;
         4'd11:   base = 20'd648548;
         4'd12:   base = 20'd621052;
         4'd13:   base = 20'd594721;
         4'd14:   base = 20'd569507;
         4'd15:   base = 20'd545362;
         default: base = 20'd1044480;
      endcase
      sh = 5'(d[7:4]) + 5'd12;
      if (d[7:4] > 4'd8) exp_lut = 8'd0;
      else exp_lut = 8'(({1'b0, base} + (21'd1 << (sh - 5'd1))) >> sh);
   endfunction

`ifdef SCORE_SIGNED_EN
   assign score_gt = $signed(score_in) > $signed(max_val);
`else
   assign score_gt = score_in > max_val;
`endif

   assign accept    = (state == S_LOAD) && score_valid;
   assign out_fire  = prob_valid && prob_ready;
   assign load_out  = (state == S_OUT) && rd_vld && (!prob_valid || prob_ready);
   assign rd_issue  = (state == S_OUT) && (cnt < n_len) && (!rd_vld || load_out);
   // The difference is 0..255 in both builds, so modulo-256 subtraction is exact.
   assign exp_d     = max_val - ram_rdata;
   assign exp_val   = exp_lut(exp_d);
   assign rem_sh    = {rem, 1'b0};
   assign rem_ge    = rem_sh >= {1'b0, sum};
   assign scaled    = 9'(({17'd0, ram_rdata} * {8'd0, recip}) >> 16);
   assign prob_next = scaled[8] ? 8'hFF : scaled[7:0];

   assign score_ready = (state == S_LOAD);
   assign busy        = (state != S_IDLE);
   assign state_dbg   = state;

   // RAM port steering: LOAD writes scores, EXP reads i and writes back i-1, OUT reads.
   always_comb begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = cnt[ADDR_WIDTH-1:0];
      ram_raddr = cnt[ADDR_WIDTH-1:0];
      ram_wdata = score_in;
      case (state)
         S_LOAD: ram_we = accept;
         S_EXP: begin
            ram_re    = cnt < n_len;
            ram_we    = cnt != '0;
            ram_waddr = ADDR_WIDTH'(cnt - CW'(1));
            ram_wdata = exp_val;
         end
         S_OUT:   ram_re = rd_issue;
         default: ;
      endcase
   end

   // Row buffer with a synchronous read port that holds its data when not read.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram[ram_raddr];
   end

   // Control FSM with datapath registers: load, exponentiate, divide, stream out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         n_len      <= '0;
         cnt        <= '0;
         out_cnt    <= '0;
         max_val    <= '0;
         sum        <= '0;
         rem        <= '0;
         div_cnt    <= '0;
         recip      <= '0;
         rd_vld     <= 1'b0;
         prob_out   <= '0;
         prob_valid <= 1'b0;
         row_done   <= 1'b0;
      end else begin
         row_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (row_start) begin
                  n_len   <= (seq_len == '0) ? CW'(MAX_SEQUENCE_LENGTH) : {1'b0, seq_len};
                  cnt     <= '0;
                  out_cnt <= '0;
                  max_val <= '0;
                  sum     <= '0;
                  rd_vld  <= 1'b0;
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (cnt == '0 || score_gt) max_val <= score_in;
                  if (cnt == n_len - CW'(1)) begin
                     cnt   <= '0;
                     state <= S_EXP;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_EXP: begin
               if (cnt != '0) sum <= sum + 19'(exp_val);
               if (cnt == n_len) begin
                  cnt     <= '0;
                  rem     <= 19'd1;
                  div_cnt <= '0;
                  recip   <= '0;
                  state   <= S_DIV;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DIV: begin
               // The leading dividend bit is preloaded into rem because sum > 1.
               // Each cycle then retires one zero dividend bit.
               rem     <= rem_ge ? 19'(rem_sh - {1'b0, sum}) : rem_sh[18:0];
               recip   <= {recip[15:0], rem_ge};
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd23) begin
                  cnt    <= '0;
                  rd_vld <= 1'b0;
                  state  <= S_OUT;
               end
            end
            S_OUT: begin
               if (rd_issue) cnt <= cnt + CW'(1);
               if (rd_issue) rd_vld <= 1'b1;
               else if (load_out) rd_vld <= 1'b0;
               if (load_out) begin
                  prob_out   <= prob_next;
                  prob_valid <= 1'b1;
               end else if (out_fire) begin
                  prob_valid <= 1'b0;
               end
               if (out_fire) begin
                  if (out_cnt == n_len - CW'(1)) begin
                     prob_valid <= 1'b0;
                     row_done   <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     out_cnt <= out_cnt + CW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qk_row_softmax.sv
// tb_qk_row_softmax: randomized bench for qk_row_softmax with a real-arithmetic
// softmax reference model and an expected-value queue.
module tb_qk_row_softmax;
   localparam int MAX_LEN = 2048;
   localparam int AW      = 11;
   localparam int BW      = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          row_start;
   logic [AW-1:0] seq_len;
   logic [BW-1:0] score_in;
   logic          score_valid;
   logic          score_ready;
   logic [BW-1:0] prob_out;
   logic          prob_valid;
   logic          prob_ready;
   logic          busy;
   logic          row_done;
   logic [2:0]    state_dbg;

   qk_row_softmax #(
      .MAX_SEQUENCE_LENGTH(MAX_LEN),
      .ADDR_WIDTH(AW),
      .BIT_WIDTH(BW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .row_start(row_start),
      .seq_len(seq_len),
      .score_in(score_in),
      .score_valid(score_valid),
      .score_ready(score_ready),
      .prob_out(prob_out),
      .prob_valid(prob_valid),
      .prob_ready(prob_ready),
      .busy(busy),
      .row_done(row_done),
      .state_dbg(state_dbg)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int total = 0;
   int bad = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] scores[MAX_LEN];
   int last_acc;
   int first_pv;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // reference model
   function automatic int lut_ref(input int d);
      real v;
      v = 255.0 * (2.0 ** (-real'(d) / 16.0));
      return $rtoi($floor(v + 0.5));
   endfunction

   function automatic bit larger(input logic [BW-1:0] a, input logic [BW-1:0] b);
`ifdef SCORE_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   task automatic model_row(input int n);
      logic [BW-1:0] mx;
      logic [BW-1:0] d;
      int e_arr[MAX_LEN];
      int sum;
      int recip;
      int p;
      mx = scores[0];
      for (int i = 1; i < n; i++) if (larger(scores[i], mx)) mx = scores[i];
      sum = 0;
      for (int i = 0; i < n; i++) begin
         d = mx - scores[i];
         e_arr[i] = lut_ref(int'(d));
         sum += e_arr[i];
      end
      recip = (1 << 24) / sum;
      for (int i = 0; i < n; i++) begin
         p = (e_arr[i] * recip) >> 16;
         if (p > 255) p = 255;
         exp_q.push_back(BW'(p));
      end
   endtask

   // driver tasks
   task automatic start_row(input int n);
      @(negedge clk);
      row_start = 1'b1;
      seq_len   = AW'(n);
      @(negedge clk);
      row_start = 1'b0;
      check("busy_rise", int'(busy), 1);
      check("ready_rise", int'(score_ready), 1);
   endtask

   task automatic drive_scores(input int n, input bit bubbles, input bit mid_start);
      int i = 0;
      int guard = 0;
      bit mid_done = 1'b0;
      while (i < n && guard < n * 4 + 100) begin
         @(negedge clk);
         guard++;
         row_start = 1'b0;
         if (mid_start && i == 1 && !mid_done) begin
            row_start = 1'b1;
            seq_len   = AW'(5);
            mid_done  = 1'b1;
         end
         if (bubbles && $urandom_range(0, 3) == 0) score_valid = 1'b0;
         else begin
            score_valid = 1'b1;
            score_in    = scores[i];
         end
         if (score_valid && score_ready) begin
            i++;
            if (i == n) last_acc = cyc_cnt + 1;
         end
      end
      @(negedge clk);
      score_valid = 1'b0;
      row_start   = 1'b0;
      check("load_count", i, n);
      check("ready_drop", int'(score_ready), 0);
   endtask

   // scoreboard consumer
   task automatic collect(input int n, input bit stall);
      int got = 0;
      int guard = 0;
      bit hold = 1'b0;
      bit seen = 1'b0;
      logic [BW-1:0] held = '0;
      logic [BW-1:0] exp;
      while (got < n && guard < n * 8 + 400) begin
         @(negedge clk);
         guard++;
         if (hold) begin
            check("hold_valid", int'(prob_valid), 1);
            check("hold_data", int'(prob_out), int'(held));
         end
         if (prob_valid && !seen) begin
            seen = 1'b1;
            first_pv = cyc_cnt;
         end
         prob_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         hold = 1'b0;
         if (prob_valid && prob_ready) begin
            exp = exp_q.pop_front();
            check("prob", int'(prob_out), int'(exp));
            got++;
         end else if (prob_valid) begin
            hold = 1'b1;
            held = prob_out;
         end
      end
      check("out_count", got, n);
      if (got == n) begin
         @(negedge clk);
         prob_ready = 1'b0;
         check("row_done", int'(row_done), 1);
         check("busy_fall", int'(busy), 0);
         @(negedge clk);
         check("row_done_pulse", int'(row_done), 0);
         check("no_extra_valid", int'(prob_valid), 0);
      end
   endtask

   task automatic run_row(input int n, input bit bubbles, input bit stall, input bit mid_start);
      model_row(n);
      first_pv = -100000;
      last_acc = 0;
      start_row(n);
      fork
         drive_scores(n, bubbles, mid_start);
         collect(n, stall);
      join
      check("latency", first_pv - last_acc, n + 27);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_score_ready"}, int'(score_ready), 0);
      check({tag, "_prob_valid"}, int'(prob_valid), 0);
      check({tag, "_prob_out"}, int'(prob_out), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_row_done"}, int'(row_done), 0);
      check({tag, "_state"}, int'(state_dbg), 0);
   endtask

   initial begin
      reset       = 1'b1;
      row_start   = 1'b0;
      seq_len     = '0;
      score_in    = '0;
      score_valid = 1'b0;
      prob_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;
      @(negedge clk);

      // score_valid in IDLE is ignored
      score_valid = 1'b1;
      score_in    = 8'h12;
      repeat (2) @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_ready", int'(score_ready), 0);
      score_valid = 1'b0;

      // single element
      scores[0] = 8'h40;
      run_row(1, 1'b0, 1'b0, 1'b0);

      // reset while in EXP
      for (int i = 0; i < 8; i++) scores[i] = BW'($urandom_range(0, 255));
      start_row(8);
      drive_scores(8, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_exp_state", int'(state_dbg), 2);
      reset = 1'b1;
      #1;
      check_reset_values("mid_exp");
      @(negedge clk);
      reset = 1'b0;

      // new row after reset; row_start during LOAD is ignored
      scores[0] = 8'd5;
      scores[1] = 8'd5;
      run_row(2, 1'b0, 1'b0, 1'b1);

      // equal pair
      scores[0] = 8'd10;
      scores[1] = 8'd10;
      run_row(2, 1'b0, 1'b1, 1'b0);

`ifdef SCORE_SIGNED_EN
      scores[0] = 8'h80;
      scores[1] = 8'h7F;
      run_row(2, 1'b0, 1'b0, 1'b0);
`else
      scores[0] = 8'd0;
      scores[1] = 8'd16;
      scores[2] = 8'd32;
      run_row(3, 1'b0, 1'b0, 1'b0);
`endif

      // random rows with input bubbles and output stalls
      for (int r = 0; r < 8; r++) begin
         int n;
         int base;
         n = $urandom_range(1, 48);
         base = $urandom_range(0, 200);
         for (int i = 0; i < n; i++) scores[i] = BW'(base + $urandom_range(0, 55));
         run_row(n, r[0], r[1], 1'b0);
      end

      // full-length row (seq_len = 0), all equal, with output stalls
      for (int i = 0; i < MAX_LEN; i++) scores[i] = 8'h33;
      run_row(MAX_LEN, 1'b0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
